pipe_mem_stage: RTL and testbench
=================================

PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: cycles in WAIT without dmem_ack before the access is aborted.
REQ-002 clock  in  1  single pipeline clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ewreg, em2reg, ewmem  in  1 each  EX-stage control: register write, load, store.
REQ-005 ealu  in  32  EX result and memory address; eb  in  32  store data; ern  in  5  EX destination register.
REQ-006 mwreg, mm2reg  out  1 each; mrn  out  5; malu  out  32  EX/MEM register contents, also to the forwarding logic.
REQ-007 mstall  out  1  freezes PC, IF/ID and ID/EX when high.
REQ-008 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32  data-memory request port.
REQ-009 dmem_ack  in  1; dmem_rdata  in  32  memory completion and read data, valid in the ack cycle.
REQ-010 wwreg, wm2reg  out  1; wrn  out  5; walu, wmo  out  32  MEM/WB register contents.
REQ-011 mem_err  out  1  sticky timeout flag.

Function
REQ-012 EX/MEM register holds {wreg, m2reg, wmem, alu, b, rn}; MEM/WB register holds {wreg, m2reg, rn, alu, mo}.
REQ-013 FSM has two states: RUN (no pending access) and WAIT (memory op in EX/MEM awaiting ack).
REQ-014 In RUN: mstall=0 and dmem_req=0; each edge loads EX/MEM from EX inputs and MEM/WB from EX/MEM, with wmo=0.
REQ-015 RUN->WAIT when the value loaded into EX/MEM has m2reg|wmem=1; otherwise stay in RUN.
REQ-016 In WAIT: dmem_req=1, dmem_addr=malu, dmem_wdata=mb, dmem_we=mwmem, all held stable until ack or abort.
REQ-017 In WAIT: mstall = ~dmem_ack & ~abort, combinational; abort is (wait_cnt == TIMEOUT-1).
REQ-018 WAIT edge with neither ack nor abort: EX/MEM holds; MEM/WB loads a bubble (wwreg=0, wm2reg=0); wait_cnt increments.
REQ-019 WAIT edge with ack: MEM/WB loads EX/MEM with wmo=dmem_rdata; EX/MEM loads EX inputs; wait_cnt clears.
REQ-020 Next state after ack follows REQ-015 on the newly loaded value, so back-to-back memory ops stay in WAIT with req deasserted for zero cycles.
REQ-021 Abort edge without ack: as REQ-019, but wwreg forced 0 and wmo=0; mem_err set; a store is treated as not performed.
REQ-022 Ack and abort in the same cycle: ack wins; mem_err unchanged.
REQ-023 dmem_ack while in RUN is ignored.
REQ-024 wait_cnt is 8 bits; TIMEOUT is legal in the range 2..255.
REQ-025 The store data path is 32-bit word only; no byte enables.

Reset
REQ-026 reset forces state=RUN, wait_cnt=0, mem_err=0, and every register and output to 0 immediately, including mid-access.
REQ-027 dmem_req falls combinationally with reset; a later ack for the abandoned access is ignored per REQ-023.
REQ-028 mem_err clears only by reset.

Structure
REQ-029 A shared package pipe_pkg holds the state enum (RUN, WAIT), the 32-bit word and 5-bit register-number widths, and the default TIMEOUT.
REQ-030 The FSM and wait counter form one sub-module, pipe_mem_fsm; the datapath registers remain in pipe_mem_stage.

Verification
REQ-031 ALU op ewreg=1, ealu=0x1234, ern=5, no memory -> mstall stays 0; two edges later wwreg=1, walu=0x1234, wrn=5.
REQ-032 Load ealu=0x40, ern=8, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req high 3 cycles, mstall high 2 cycles, two bubbles, then wm2reg=1, wmo=0xDEADBEEF, wrn=8.
REQ-033 Store eb=0xA5A5A5A5, ealu=0x80, followed by a load, ack each in cycle 1 -> dmem_we=1 then 0, req continuously high, no bubbles.
REQ-034 Load with no ack, TIMEOUT=16 -> 16 req cycles, then mem_err=1, wwreg=0, wmo=0, FSM in RUN.
REQ-035 reset asserted in the 2nd WAIT cycle, then a late ack -> all outputs 0 at once; the ack produces no writeback.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the memory pipeline stage.
package pipe_pkg;

  localparam int WORD_W          = 32;
  localparam int REG_W           = 5;
  localparam int CNT_W           = 8;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } memState_t;

  // An instruction needs the data memory if it loads or stores.
  function automatic logic isMemOp(input logic m2reg, input logic wmem);
    return m2reg | wmem;
  endfunction

endpackage

// File: rtl/pipe_mem_fsm.sv
// RUN/WAIT controller with the access timeout counter and sticky error flag.
// TIMEOUT must lie in 2..255 so that TIMEOUT-1 fits the 8-bit counter.
module pipe_mem_fsm
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_memNext,
  input  logic i_ack,
  output logic o_wait,
  output logic o_stall,
  output logic o_advance,
  output logic o_ackTaken,
  output logic o_abortOnly,
  output logic o_memErr
);

  memState_t        r_state;
  memState_t        w_nextState;
  logic [CNT_W-1:0] r_waitCnt;
  logic             r_memErr;
  logic             w_inWait;
  logic             w_abort;

  assign w_inWait = (r_state == WAIT);
  assign w_abort  = w_inWait && (r_waitCnt == CNT_W'(TIMEOUT - 1));

  // State register; reset abandons any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_nextState;
  end

  // Leaving an access (ack or abort) re-evaluates the instruction entering EX/MEM.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:     w_nextState = i_memNext ? WAIT : RUN;
      WAIT:    if (i_ack || w_abort) w_nextState = i_memNext ? WAIT : RUN;
      default: w_nextState = RUN;
    endcase
  end

  // Stall/advance decode; an ack in the abort cycle takes precedence.
  always_comb begin
    o_wait      = w_inWait;
    o_ackTaken  = w_inWait & i_ack;
    o_abortOnly = w_abort & ~i_ack;
    o_stall     = w_inWait & ~i_ack & ~w_abort;
    o_advance   = ~w_inWait | i_ack | w_abort;
  end

  // Counts waiting cycles of the current access; clears whenever it ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            r_waitCnt <= '0;
    else if (w_inWait && !(i_ack || w_abort)) r_waitCnt <= r_waitCnt + CNT_W'(1);
    else                                  r_waitCnt <= '0;
  end

  // Timeout flag stays set until the next reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            r_memErr <= 1'b0;
    else if (o_abortOnly) r_memErr <= 1'b1;
  end

  assign o_memErr = r_memErr;

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: EX/MEM and MEM/WB registers around a stalling data-memory port.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic [WORD_W-1:0] ealu,
  input  logic [WORD_W-1:0] eb,
  input  logic [REG_W-1:0]  ern,
  output logic              mwreg,
  output logic              mm2reg,
  output logic [REG_W-1:0]  mrn,
  output logic [WORD_W-1:0] malu,
  output logic              mstall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [REG_W-1:0]  wrn,
  output logic [WORD_W-1:0] walu,
  output logic [WORD_W-1:0] wmo,
  output logic              mem_err
);

  logic              r_mWreg, r_mM2reg, r_mWmem;
  logic [WORD_W-1:0] r_mAlu, r_mB;
  logic [REG_W-1:0]  r_mRn;
  logic              r_wWreg, r_wM2reg;
  logic [REG_W-1:0]  r_wRn;
  logic [WORD_W-1:0] r_wAlu, r_wMo;

  logic w_memNext, w_wait, w_stall, w_advance, w_ackTaken, w_abortOnly, w_req;

  assign w_memNext = isMemOp(em2reg, ewmem);

  pipe_mem_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clock       (clock),
    .reset       (reset),
    .i_memNext   (w_memNext),
    .i_ack       (dmem_ack),
    .o_wait      (w_wait),
    .o_stall     (w_stall),
    .o_advance   (w_advance),
    .o_ackTaken  (w_ackTaken),
    .o_abortOnly (w_abortOnly),
    .o_memErr    (mem_err)
  );

  // EX/MEM captures the EX stage unless an access is still outstanding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mWreg  <= 1'b0;
      r_mM2reg <= 1'b0;
      r_mWmem  <= 1'b0;
      r_mAlu   <= '0;
      r_mB     <= '0;
      r_mRn    <= '0;
    end else if (w_advance) begin
      r_mWreg  <= ewreg;
      r_mM2reg <= em2reg;
      r_mWmem  <= ewmem;
      r_mAlu   <= ealu;
      r_mB     <= eb;
      r_mRn    <= ern;
    end
  end

  // MEM/WB takes the finished instruction, or a bubble while the access waits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wWreg  <= 1'b0;
      r_wM2reg <= 1'b0;
      r_wRn    <= '0;
      r_wAlu   <= '0;
      r_wMo    <= '0;
    end else if (w_advance) begin
      r_wWreg  <= r_mWreg & ~w_abortOnly;
      r_wM2reg <= r_mM2reg;
      r_wRn    <= r_mRn;
      r_wAlu   <= r_mAlu;
      r_wMo    <= w_ackTaken ? dmem_rdata : '0;
    end else begin
      r_wWreg  <= 1'b0;
      r_wM2reg <= 1'b0;
      r_wRn    <= '0;
      r_wAlu   <= '0;
      r_wMo    <= '0;
    end
  end

  assign w_req      = w_wait & ~reset;
  assign dmem_req   = w_req;
  assign dmem_we    = w_req & r_mWmem;
  assign dmem_addr  = w_req ? r_mAlu : '0;
  assign dmem_wdata = w_req ? r_mB : '0;
  assign mstall     = w_stall & ~reset;

  assign mwreg  = r_mWreg;
  assign mm2reg = r_mM2reg;
  assign mrn    = r_mRn;
  assign malu   = r_mAlu;
  assign wwreg  = r_wWreg;
  assign wm2reg = r_wM2reg;
  assign wrn    = r_wRn;
  assign walu   = r_wAlu;
  assign wmo    = r_wMo;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Scoreboard bench for pipe_mem_stage: a driver issues instructions and predicts
// their effects, a memory responder acks with planned latencies, and a monitor
// compares whatever the DUT presents against the predictions.
module tb_pipe_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        ewreg, em2reg, ewmem;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        mwreg, mm2reg;
  logic [4:0]  mrn;
  logic [31:0] malu;
  logic        mstall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wwreg, wm2reg;
  logic [4:0]  wrn;
  logic [31:0] walu, wmo;
  logic        mem_err;

  typedef struct {
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  wrn;
    logic [31:0] walu;
    logic [31:0] wmo;
  } wbItem_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memItem_t;

  wbItem_t     wbQ[$];
  memItem_t    memQ[$];
  int          latQ[$];
  logic [31:0] modelMem[logic [31:0]];
  logic [31:0] memArr[logic [31:0]];

  int       nChecks = 0;
  int       nFails  = 0;
  bit       monOn   = 1'b0;
  bit       respOn  = 1'b1;
  bit       lateAck = 1'b0;
  bit       expErr  = 1'b0;
  int       monCycle = 0;
  int       reqCycle = 0;
  int       curLat   = 0;
  memItem_t curMem;
  wbItem_t  curWb;

  always #5 clock = ~clock;

  pipe_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .ewreg      (ewreg),
    .em2reg     (em2reg),
    .ewmem      (ewmem),
    .ealu       (ealu),
    .eb         (eb),
    .ern        (ern),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mrn        (mrn),
    .malu       (malu),
    .mstall     (mstall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .wrn        (wrn),
    .walu       (walu),
    .wmo        (wmo),
    .mem_err    (mem_err)
  );

  // Contents of a never-written memory word.
  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    return modelMem.exists(a) ? modelMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : initWord(a);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Predict the instruction's visible effects, then hold it on the EX inputs
  // until the stage accepts it. Latency lat: ack in request cycle lat, 0 = never.
  task automatic applyStimulus(input logic wreg, input logic m2reg, input logic wmem,
                               input logic [31:0] alu, input logic [31:0] b,
                               input logic [4:0] rn, input int lat);
    bit       acked;
    bit       consumed;
    wbItem_t  w;
    memItem_t m;
    acked = 1'b1;
    if (m2reg || wmem) begin
      acked = (lat >= 1) && (lat <= TIMEOUT);
      latQ.push_back(lat);
      m.we    = wmem;
      m.addr  = alu;
      m.wdata = b;
      memQ.push_back(m);
    end
    if (wreg || m2reg) begin
      w.wwreg  = wreg && acked;
      w.wm2reg = m2reg;
      w.wrn    = rn;
      w.walu   = alu;
      w.wmo    = (m2reg && acked) ? modelRead(alu) : 32'd0;
      wbQ.push_back(w);
    end
    if (wmem && acked) modelMem[alu] = b;
    ewreg  = wreg;
    em2reg = m2reg;
    ewmem  = wmem;
    ealu   = alu;
    eb     = b;
    ern    = rn;
    consumed = 1'b0;
    for (int c = 0; c < 200 && !consumed; c++) begin
      @(negedge clock);
      consumed = !mstall;
      @(posedge clock);
      #1;
    end
    if (!consumed) reportFail("issue stuck behind mstall");
  endtask

  // Memory responder: acks each request in its planned cycle; stray acks while idle.
  initial begin
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(posedge clock);
      #2;
      if (!respOn) begin
        dmem_ack   = lateAck;
        dmem_rdata = 32'hDEADBEEF;
      end else if (dmem_req) begin
        reqCycle++;
        if (reqCycle == 1) curLat = (latQ.size() > 0) ? latQ.pop_front() : 1;
        if (curLat == reqCycle) begin
          dmem_ack = 1'b1;
          if (dmem_we) memArr[dmem_addr] = dmem_wdata;
          dmem_rdata = memRead(dmem_addr);
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
        end
        if (dmem_ack || reqCycle == TIMEOUT) reqCycle = 0;
      end else begin
        reqCycle   = 0;
        dmem_ack   = ($urandom_range(0, 7) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // Monitor: checks each request, the stall line, the error flag and writebacks.
  initial begin
    forever begin
      @(negedge clock);
      if (monOn) begin
        checkOutput("mem_err", 64'(mem_err), 64'(expErr));
        if (dmem_req) begin
          monCycle++;
          if (monCycle == 1) begin
            if (memQ.size() == 0) begin
              reportFail("unexpected memory request");
              curMem = '{we: 1'b0, addr: 32'd0, wdata: 32'd0};
            end else begin
              curMem = memQ.pop_front();
            end
          end
          checkOutput("dmem_addr", 64'(dmem_addr), 64'(curMem.addr));
          checkOutput("dmem_we", 64'(dmem_we), 64'(curMem.we));
          checkOutput("dmem_wdata", 64'(dmem_wdata), 64'(curMem.wdata));
          checkOutput("mstall waiting", 64'(mstall), 64'(!dmem_ack && monCycle < TIMEOUT));
          if (dmem_ack || monCycle == TIMEOUT) begin
            if (!dmem_ack) expErr = 1'b1;
            monCycle = 0;
          end
        end else begin
          checkOutput("mstall idle", 64'(mstall), 64'd0);
        end
        if (wwreg || wm2reg) begin
          if (wbQ.size() == 0) begin
            reportFail("unexpected writeback");
          end else begin
            curWb = wbQ.pop_front();
            checkOutput("wwreg", 64'(wwreg), 64'(curWb.wwreg));
            checkOutput("wm2reg", 64'(wm2reg), 64'(curWb.wm2reg));
            checkOutput("wrn", 64'(wrn), 64'(curWb.wrn));
            checkOutput("walu", 64'(walu), 64'(curWb.walu));
            checkOutput("wmo", 64'(wmo), 64'(curWb.wmo));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          kind;
    int          r;
    int          lat;

    reset  = 1'b1;
    ewreg  = 1'b0;
    em2reg = 1'b0;
    ewmem  = 1'b0;
    ealu   = 32'd0;
    eb     = 32'd0;
    ern    = 5'd0;
    memArr[32'h40]   = 32'hDEADBEEF;
    modelMem[32'h40] = 32'hDEADBEEF;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset mstall", 64'(mstall), 64'd0);
    checkOutput("reset dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("reset dmem_we", 64'(dmem_we), 64'd0);
    checkOutput("reset dmem_addr", 64'(dmem_addr), 64'd0);
    checkOutput("reset mwreg", 64'(mwreg), 64'd0);
    checkOutput("reset mrn", 64'(mrn), 64'd0);
    checkOutput("reset malu", 64'(malu), 64'd0);
    checkOutput("reset wwreg", 64'(wwreg), 64'd0);
    checkOutput("reset wm2reg", 64'(wm2reg), 64'd0);
    checkOutput("reset walu", 64'(walu), 64'd0);
    checkOutput("reset wmo", 64'(wmo), 64'd0);
    checkOutput("reset mem_err", 64'(mem_err), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    monOn = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h77, 5'd8, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd3, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd9, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 5'd10, TIMEOUT);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hCAFE, 32'h0, 5'd11, 0);

    $display("[TB] random sequence");
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 19);
      addr = 32'($urandom_range(0, 15)) << 2;
      r    = $urandom_range(0, 24);
      lat  = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT - 1 : 1 + (r % 4);
      if (kind < 8)
        applyStimulus(1'b1, 1'b0, 1'b0, 32'($urandom), 32'($urandom), 5'($urandom), 0);
      else if (kind < 13)
        applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'($urandom), 5'($urandom), lat);
      else if (kind < 17)
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 32'($urandom), 5'($urandom), lat);
      else
        applyStimulus(1'b0, 1'b0, 1'b0, 32'($urandom), 32'($urandom), 5'($urandom), 0);
    end

    for (int c = 0; c < 400; c++) begin
      if (wbQ.size() == 0 && memQ.size() == 0 && !dmem_req) break;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0);
    end
    checkOutput("writebacks drained", 64'(wbQ.size()), 64'd0);
    checkOutput("requests drained", 64'(memQ.size()), 64'd0);
    checkOutput("latencies drained", 64'(latQ.size()), 64'd0);

    $display("[TB] reset during access");
    monOn = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 0);
    ewreg  = 1'b0;
    em2reg = 1'b0;
    ewmem  = 1'b0;
    ealu   = 32'd0;
    eb     = 32'd0;
    ern    = 5'd0;
    wbQ.delete();
    memQ.delete();
    @(posedge clock);
    #3;
    respOn = 1'b0;
    checkOutput("pre-reset dmem_req", 64'(dmem_req), 64'd1);
    checkOutput("pre-reset mstall", 64'(mstall), 64'd1);
    checkOutput("pre-reset malu", 64'(malu), 64'h100);
    reset = 1'b1;
    #1;
    checkOutput("async reset dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("async reset mstall", 64'(mstall), 64'd0);
    checkOutput("async reset dmem_addr", 64'(dmem_addr), 64'd0);
    checkOutput("async reset mm2reg", 64'(mm2reg), 64'd0);
    checkOutput("async reset malu", 64'(malu), 64'd0);
    checkOutput("async reset mrn", 64'(mrn), 64'd0);
    checkOutput("async reset mem_err", 64'(mem_err), 64'd0);
    @(negedge clock);
    reset   = 1'b0;
    lateAck = 1'b1;
    @(negedge clock);
    checkOutput("late ack dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("late ack mstall", 64'(mstall), 64'd0);
    lateAck = 1'b0;
    @(negedge clock);
    checkOutput("late ack wwreg", 64'(wwreg), 64'd0);
    checkOutput("late ack wm2reg", 64'(wm2reg), 64'd0);
    checkOutput("late ack wmo", 64'(wmo), 64'd0);
    checkOutput("late ack mem_err", 64'(mem_err), 64'd0);
    checkOutput("late ack dmem_req idle", 64'(dmem_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
